// File: rtl/rx_axis2mm_bridge.sv
// rx_axis2mm_bridge: RX AXI-Stream frames land in a byte FIFO, are committed whole, then read as MM words.
// Build option: define RX_FCS_STRIP_EN to strip the trailing 4-byte FCS from every committed frame.
module rx_axis2mm_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int FIFO_BYTES      = 4096,
  parameter int LEN_DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mac_enable,
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          rxr_data,
  output logic                           rxr_valid,
  input  logic                           rxr_pop,
  output logic [15:0]                    rx_len,
  output logic [$clog2(LEN_DEPTH+1)-1:0] rx_frames,
  output logic [15:0]                    rx_level,
  output logic                           ev_rx_done,
  output logic [15:0]                    rx_drop_cnt,
  output logic                           rx_overflow,
  input  logic                           rx_ovf_clr
);

  localparam int AX_BYTES = AXIS_DATA_WIDTH / 8;
  localparam int MM_BYTES = DATA_WIDTH / 8;
  localparam int AW       = $clog2(FIFO_BYTES);
  localparam int PW       = AW + 1;
  localparam int LW       = $clog2(LEN_DEPTH);
  localparam int QW       = LW + 1;
  localparam int BW       = $clog2(AX_BYTES + 1);
  localparam logic [PW-1:0] FIFO_SIZE = PW'(FIFO_BYTES);
`ifdef RX_FCS_STRIP_EN
  localparam logic [16:0] FCS_BYTES = 17'd4;
`else
  localparam logic [16:0] FCS_BYTES = 17'd0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  function automatic logic [BW-1:0] popcount(input logic [AX_BYTES-1:0] keep);
    logic [BW-1:0] cnt;
    cnt = '0;
    for (int i = 32'sd0; i < AX_BYTES; i++) begin
      cnt = cnt + BW'(keep[i]);
    end
    return cnt;
  endfunction

  wr_state_e     state_r, state_nxt_s;
  logic [PW-1:0] wptr_r, wptr_tmp_r, rd_ptr_r;
  logic [PW-1:0] wptr_nxt_s, wptr_tmp_nxt_s;
  logic [15:0]   flen_r, flen_nxt_s;
  logic [15:0]   rd_off_r;
  logic [QW-1:0] lq_wr_r, lq_rd_r;
  logic [15:0]   len_mem_r [LEN_DEPTH];
  logic [7:0]    fifo_mem_r [FIFO_BYTES];

  logic [BW-1:0] beat_bytes_s;
  logic [16:0]   flen_sum_s;
  logic [15:0]   commit_len_s;
  logic [PW-1:0] used_s, free_s;
  logic          no_room_s, lq_full_s, accept_s;
  logic          wr_en_s, commit_s, drop_s, ovf_set_s;
  logic [QW-1:0] frames_s;
  logic [15:0]   head_len_s, rem_s, n_s;
  logic          pop_s, pop_last_s;
  logic [31:0]   level_wide_s;

  assign s_axis_tready = 1'b1;

  // Read-side view of the head frame: remaining bytes and size of the current word.
  always_comb begin
    frames_s   = lq_wr_r - lq_rd_r;
    head_len_s = 16'd0;
    if (frames_s != '0) begin
      head_len_s = len_mem_r[lq_rd_r[LW-1:0]];
    end else begin
      head_len_s = 16'd0;
    end
    rem_s = head_len_s - rd_off_r;
    if (rem_s > 16'(MM_BYTES)) begin
      n_s = 16'(MM_BYTES);
    end else begin
      n_s = rem_s;
    end
    pop_s      = rxr_pop && (frames_s != '0);
    pop_last_s = pop_s && (rem_s == n_s);
  end

  // Read window: up to MM_BYTES bytes from rd_ptr, lane 0 first, unused lanes zero.
  always_comb begin
    rxr_data = '0;
    for (int j = 32'sd0; j < MM_BYTES; j++) begin
      if (16'(j) < n_s) begin
        rxr_data[(32'sd8 * j) +: 8] = fifo_mem_r[rd_ptr_r[AW-1:0] + AW'(j)];
      end else begin
        rxr_data[(32'sd8 * j) +: 8] = 8'd0;
      end
    end
  end

  // Write-side FSM next state: accept, drop or commit the current beat.
  always_comb begin
    state_nxt_s    = state_r;
    wptr_nxt_s     = wptr_r;
    wptr_tmp_nxt_s = wptr_tmp_r;
    flen_nxt_s     = flen_r;
    accept_s       = 1'b0;
    wr_en_s        = 1'b0;
    commit_s       = 1'b0;
    drop_s         = 1'b0;
    ovf_set_s      = 1'b0;
    beat_bytes_s   = popcount(s_axis_tkeep);
    flen_sum_s     = {1'b0, flen_r} + 17'(beat_bytes_s);
    commit_len_s   = flen_sum_s[15:0] - FCS_BYTES[15:0];
    used_s         = wptr_tmp_r - rd_ptr_r;
    free_s         = FIFO_SIZE - used_s;
    no_room_s      = free_s < PW'(beat_bytes_s);
    // A head frame draining this cycle frees its queue slot for a same-cycle commit.
    lq_full_s      = (frames_s == QW'(LEN_DEPTH)) && !pop_last_s;

    case (state_r)
      ST_IDLE: begin
        if (!s_axis_tvalid) begin
          state_nxt_s = ST_IDLE;
        end else if (mac_enable) begin
          accept_s = 1'b1;
        end else if (!s_axis_tlast) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (s_axis_tvalid) begin
          accept_s = 1'b1;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      if (no_room_s || flen_sum_s[16]) begin
        wptr_tmp_nxt_s = wptr_r;
        flen_nxt_s     = 16'd0;
        drop_s         = 1'b1;
        ovf_set_s      = 1'b1;
        state_nxt_s    = s_axis_tlast ? ST_IDLE : ST_DROP;
      end else begin
        wr_en_s        = 1'b1;
        wptr_tmp_nxt_s = wptr_tmp_r + PW'(beat_bytes_s);
        flen_nxt_s     = flen_sum_s[15:0];
        state_nxt_s    = ST_RECV;
        if (s_axis_tlast) begin
          flen_nxt_s  = 16'd0;
          state_nxt_s = ST_IDLE;
          if (!s_axis_tuser && (flen_sum_s > FCS_BYTES) && !lq_full_s) begin
            commit_s       = 1'b1;
            wptr_nxt_s     = wptr_tmp_r + PW'(beat_bytes_s) - PW'(FCS_BYTES);
            wptr_tmp_nxt_s = wptr_nxt_s;
          end else begin
            wptr_tmp_nxt_s = wptr_r;
            drop_s         = 1'b1;
            ovf_set_s      = lq_full_s && !s_axis_tuser;
          end
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Write-side FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointers, frame length and length-queue indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r     <= '0;
      wptr_tmp_r <= '0;
      flen_r     <= 16'd0;
      rd_ptr_r   <= '0;
      rd_off_r   <= 16'd0;
      lq_wr_r    <= '0;
      lq_rd_r    <= '0;
    end else begin
      wptr_r     <= wptr_nxt_s;
      wptr_tmp_r <= wptr_tmp_nxt_s;
      flen_r     <= flen_nxt_s;
      if (commit_s) begin
        lq_wr_r <= lq_wr_r + QW'(32'd1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(n_s);
        if (pop_last_s) begin
          rd_off_r <= 16'd0;
          lq_rd_r  <= lq_rd_r + QW'(32'd1);
        end else begin
          rd_off_r <= rd_off_r + n_s;
        end
      end
    end
  end

  // Byte FIFO and length queue storage; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 32'sd0; i < AX_BYTES; i++) begin
        if (s_axis_tkeep[i]) begin
          fifo_mem_r[wptr_tmp_r[AW-1:0] + AW'(i)] <= s_axis_tdata[(32'sd8 * i) +: 8];
        end
      end
    end
    if (commit_s) begin
      len_mem_r[lq_wr_r[LW-1:0]] <= commit_len_s;
    end
  end

  // Status: commit pulse, saturating drop counter and sticky overflow (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_rx_done  <= 1'b0;
      rx_drop_cnt <= 16'd0;
      rx_overflow <= 1'b0;
    end else begin
      ev_rx_done <= commit_s;
      if (drop_s && (rx_drop_cnt != 16'hFFFF)) begin
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
      if (ovf_set_s) begin
        rx_overflow <= 1'b1;
      end else if (rx_ovf_clr) begin
        rx_overflow <= 1'b0;
      end
    end
  end

  // CSR-facing status decoded from registered state.
  always_comb begin
    rxr_valid    = (frames_s != '0);
    rx_len       = head_len_s;
    rx_frames    = frames_s;
    level_wide_s = 32'(used_s);
    if (level_wide_s > 32'd65535) begin
      rx_level = 16'hFFFF;
    end else begin
      rx_level = level_wide_s[15:0];
    end
  end

endmodule

// File: tb/tb_rx_axis2mm_bridge.sv
// Directed self-checking bench for rx_axis2mm_bridge (64-byte FIFO, 4-deep length queue, 8-bit AXIS, 32-bit MM).
module tb_rx_axis2mm_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mac_enable = 1'b1;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic [0:0]  s_axis_tkeep = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [31:0] rxr_data;
  logic        rxr_valid;
  logic        rxr_pop = 1'b0;
  logic [15:0] rx_len;
  logic [2:0]  rx_frames;
  logic [15:0] rx_level;
  logic        ev_rx_done;
  logic [15:0] rx_drop_cnt;
  logic        rx_overflow;
  logic        rx_ovf_clr = 1'b0;

  int checks = 0;
  int passes = 0;
  int ev_count = 0;

  rx_axis2mm_bridge #(
    .DATA_WIDTH(32), .AXIS_DATA_WIDTH(8), .FIFO_BYTES(64), .LEN_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .mac_enable(mac_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .rxr_data(rxr_data), .rxr_valid(rxr_valid), .rxr_pop(rxr_pop),
    .rx_len(rx_len), .rx_frames(rx_frames), .rx_level(rx_level), .ev_rx_done(ev_rx_done),
    .rx_drop_cnt(rx_drop_cnt), .rx_overflow(rx_overflow), .rx_ovf_clr(rx_ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ev_rx_done) ev_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int base, input int len, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (w * 4 + b < len) r[8*b +: 8] = 8'(base + w * 4 + b);
    end
    return r;
  endfunction

  task automatic send_frame(input int len, input int base, input logic user);
    for (int i = 0; i < len; i++) begin
      s_axis_tdata  = 8'(base + i);
      s_axis_tkeep  = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? user : 1'b0;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic pop_word(output logic [31:0] d, output logic v);
    d = rxr_data;
    v = rxr_valid;
    rxr_pop = 1'b1;
    tick();
    rxr_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (s_axis_tready !== 1'b1) $display("FAIL rst_tready got %0b want 1", s_axis_tready); else passes++;
    checks++; if (rxr_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", rxr_valid); else passes++;
    checks++; if (rx_len !== 16'd0) $display("FAIL rst_len got %0d want 0", rx_len); else passes++;
    checks++; if (rx_frames !== 3'd0) $display("FAIL rst_frames got %0d want 0", rx_frames); else passes++;
    checks++; if (ev_rx_done !== 1'b0) $display("FAIL rst_ev got %0b want 0", ev_rx_done); else passes++;
    checks++; if (rx_drop_cnt !== 16'd0) $display("FAIL rst_drop got %0d want 0", rx_drop_cnt); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL rst_ovf got %0b want 0", rx_overflow); else passes++;
    checks++; if (rx_level !== 16'd0) $display("FAIL rst_level got %0d want 0", rx_level); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame60();
    logic [31:0] d;
    logic v;
    int ev0;
    ev0 = ev_count;
    send_frame(60, 0, 1'b0);
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL f60_ev got %0b want 1", ev_rx_done); else passes++;
    checks++; if (rx_len !== 16'd60) $display("FAIL f60_len got %0d want 60", rx_len); else passes++;
    checks++; if (rx_frames !== 3'd1) $display("FAIL f60_frames got %0d want 1", rx_frames); else passes++;
    checks++; if (rx_level !== 16'd60) $display("FAIL f60_level got %0d want 60", rx_level); else passes++;
    tick();
    checks++; if (ev_count - ev0 !== 1) $display("FAIL f60_evcount got %0d want 1", ev_count - ev0); else passes++;
    for (int w = 0; w < 15; w++) begin
      pop_word(d, v);
      checks++; if (v !== 1'b1) $display("FAIL f60_valid w%0d got %0b want 1", w, v); else passes++;
      checks++; if (d !== exp_word(0, 60, w)) $display("FAIL f60_data w%0d got %h want %h", w, d, exp_word(0, 60, w)); else passes++;
    end
    checks++; if (rxr_valid !== 1'b0) $display("FAIL f60_end_valid got %0b want 0", rxr_valid); else passes++;
    checks++; if (rx_len !== 16'd0) $display("FAIL f60_end_len got %0d want 0", rx_len); else passes++;
    checks++; if (rx_level !== 16'd0) $display("FAIL f60_end_level got %0d want 0", rx_level); else passes++;
  endtask

  task automatic test_frame61();
    logic [31:0] d;
    logic v;
    send_frame(61, 100, 1'b0);
    checks++; if (rx_len !== 16'd61) $display("FAIL f61_len got %0d want 61", rx_len); else passes++;
    for (int w = 0; w < 16; w++) begin
      pop_word(d, v);
      checks++; if (d !== exp_word(100, 61, w)) $display("FAIL f61_data w%0d got %h want %h", w, d, exp_word(100, 61, w)); else passes++;
    end
    checks++; if (d !== 32'h0000_00A0) $display("FAIL f61_tail got %h want 000000a0", d); else passes++;
    checks++; if (rx_frames !== 3'd0) $display("FAIL f61_frames got %0d want 0", rx_frames); else passes++;
  endtask

  task automatic test_tuser_err();
    int ev0;
    ev0 = ev_count;
    send_frame(10, 7, 1'b1);
    checks++; if (ev_rx_done !== 1'b0) $display("FAIL err_ev got %0b want 0", ev_rx_done); else passes++;
    tick();
    checks++; if (ev_count - ev0 !== 0) $display("FAIL err_evcount got %0d want 0", ev_count - ev0); else passes++;
    checks++; if (rx_drop_cnt !== 16'd1) $display("FAIL err_drop got %0d want 1", rx_drop_cnt); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL err_ovf got %0b want 0", rx_overflow); else passes++;
    checks++; if (rx_level !== 16'd0) $display("FAIL err_level got %0d want 0", rx_level); else passes++;
    checks++; if (rx_frames !== 3'd0) $display("FAIL err_frames got %0d want 0", rx_frames); else passes++;
  endtask

  task automatic test_mac_enable();
    logic [31:0] d;
    logic v;
    int ev0;
    ev0 = ev_count;
    mac_enable = 1'b0;
    send_frame(6, 9, 1'b0);
    tick();
    checks++; if (ev_count - ev0 !== 0) $display("FAIL men_evcount got %0d want 0", ev_count - ev0); else passes++;
    checks++; if (rx_drop_cnt !== 16'd1) $display("FAIL men_drop got %0d want 1", rx_drop_cnt); else passes++;
    checks++; if (rx_level !== 16'd0) $display("FAIL men_level got %0d want 0", rx_level); else passes++;
    mac_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata  = 8'(8'h30 + i);
      s_axis_tkeep  = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 4);
      tick();
      mac_enable = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL men_ev got %0b want 1", ev_rx_done); else passes++;
    checks++; if (rx_len !== 16'd5) $display("FAIL men_len got %0d want 5", rx_len); else passes++;
    for (int w = 0; w < 2; w++) begin
      pop_word(d, v);
      checks++; if (d !== exp_word(8'h30, 5, w)) $display("FAIL men_data w%0d got %h want %h", w, d, exp_word(8'h30, 5, w)); else passes++;
    end
    mac_enable = 1'b1;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic v;
    int ev0;
    ev0 = ev_count;
    send_frame(40, 8'h40, 1'b0);
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL ovf_ev1 got %0b want 1", ev_rx_done); else passes++;
    send_frame(40, 8'h80, 1'b0);
    checks++; if (ev_rx_done !== 1'b0) $display("FAIL ovf_ev2 got %0b want 0", ev_rx_done); else passes++;
    tick();
    checks++; if (ev_count - ev0 !== 1) $display("FAIL ovf_evcount got %0d want 1", ev_count - ev0); else passes++;
    checks++; if (rx_frames !== 3'd1) $display("FAIL ovf_frames got %0d want 1", rx_frames); else passes++;
    checks++; if (rx_len !== 16'd40) $display("FAIL ovf_len got %0d want 40", rx_len); else passes++;
    checks++; if (rx_level !== 16'd40) $display("FAIL ovf_level got %0d want 40", rx_level); else passes++;
    checks++; if (rx_drop_cnt !== 16'd2) $display("FAIL ovf_drop got %0d want 2", rx_drop_cnt); else passes++;
    checks++; if (rx_overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", rx_overflow); else passes++;
    rx_ovf_clr = 1'b1;
    tick();
    rx_ovf_clr = 1'b0;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL ovf_clr got %0b want 0", rx_overflow); else passes++;
    for (int w = 0; w < 10; w++) begin
      pop_word(d, v);
      checks++; if (d !== exp_word(8'h40, 40, w)) $display("FAIL ovf_data w%0d got %h want %h", w, d, exp_word(8'h40, 40, w)); else passes++;
    end
    checks++; if (rxr_valid !== 1'b0) $display("FAIL ovf_end_valid got %0b want 0", rxr_valid); else passes++;
  endtask

  task automatic test_len_queue();
    logic [31:0] d;
    logic v;
    for (int f = 0; f < 5; f++) send_frame(8, 16 * f, 1'b0);
    tick();
    checks++; if (rx_frames !== 3'd4) $display("FAIL lq_frames got %0d want 4", rx_frames); else passes++;
    checks++; if (rx_drop_cnt !== 16'd3) $display("FAIL lq_drop got %0d want 3", rx_drop_cnt); else passes++;
    checks++; if (rx_overflow !== 1'b1) $display("FAIL lq_ovf got %0b want 1", rx_overflow); else passes++;
    checks++; if (rx_level !== 16'd32) $display("FAIL lq_level got %0d want 32", rx_level); else passes++;
    pop_word(d, v);
    checks++; if (d !== exp_word(0, 8, 0)) $display("FAIL lq_head0 got %h want %h", d, exp_word(0, 8, 0)); else passes++;
    // New frame's tlast lands on the same edge as the head frame's final pop.
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata  = 8'(8'h50 + i);
      s_axis_tkeep  = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 7);
      if (i == 7) begin
        d = rxr_data;
        rxr_pop = 1'b1;
      end
      tick();
    end
    rxr_pop       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++; if (d !== exp_word(0, 8, 1)) $display("FAIL lq_head1 got %h want %h", d, exp_word(0, 8, 1)); else passes++;
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL lq_same_ev got %0b want 1", ev_rx_done); else passes++;
    checks++; if (rx_frames !== 3'd4) $display("FAIL lq_same_frames got %0d want 4", rx_frames); else passes++;
    checks++; if (rx_level !== 16'd32) $display("FAIL lq_same_level got %0d want 32", rx_level); else passes++;
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 2; w++) begin
        pop_word(d, v);
        checks++;
        if (d !== exp_word((f == 3) ? 8'h50 : 16 * (f + 1), 8, w))
          $display("FAIL lq_data f%0d w%0d got %h want %h", f, w, d, exp_word((f == 3) ? 8'h50 : 16 * (f + 1), 8, w));
        else passes++;
      end
    end
    checks++; if (rxr_valid !== 1'b0) $display("FAIL lq_end_valid got %0b want 0", rxr_valid); else passes++;
    rx_ovf_clr = 1'b1;
    tick();
    rx_ovf_clr = 1'b0;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL lq_clr got %0b want 0", rx_overflow); else passes++;
  endtask

  task automatic test_fcs();
    logic [31:0] d;
    logic v;
    send_frame(64, 8'hA0, 1'b0);
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL fcs_ev got %0b want 1", ev_rx_done); else passes++;
`ifdef RX_FCS_STRIP_EN
    checks++; if (rx_len !== 16'd60) $display("FAIL fcs_len got %0d want 60", rx_len); else passes++;
    checks++; if (rx_level !== 16'd60) $display("FAIL fcs_level got %0d want 60", rx_level); else passes++;
    for (int w = 0; w < 15; w++) begin
      pop_word(d, v);
      checks++; if (d !== exp_word(8'hA0, 60, w)) $display("FAIL fcs_data w%0d got %h want %h", w, d, exp_word(8'hA0, 60, w)); else passes++;
    end
    checks++; if (rxr_valid !== 1'b0) $display("FAIL fcs_end_valid got %0b want 0", rxr_valid); else passes++;
    checks++; if (rx_level !== 16'd0) $display("FAIL fcs_end_level got %0d want 0", rx_level); else passes++;
    send_frame(4, 8'h11, 1'b0);
    checks++; if (ev_rx_done !== 1'b0) $display("FAIL fcs_short_ev got %0b want 0", ev_rx_done); else passes++;
    checks++; if (rx_drop_cnt !== 16'd4) $display("FAIL fcs_short_drop got %0d want 4", rx_drop_cnt); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL fcs_short_ovf got %0b want 0", rx_overflow); else passes++;
    checks++; if (rx_frames !== 3'd0) $display("FAIL fcs_short_frames got %0d want 0", rx_frames); else passes++;
`else
    checks++; if (rx_len !== 16'd64) $display("FAIL full_len got %0d want 64", rx_len); else passes++;
    checks++; if (rx_level !== 16'd64) $display("FAIL full_level got %0d want 64", rx_level); else passes++;
    for (int w = 0; w < 16; w++) begin
      pop_word(d, v);
      checks++; if (d !== exp_word(8'hA0, 64, w)) $display("FAIL full_data w%0d got %h want %h", w, d, exp_word(8'hA0, 64, w)); else passes++;
    end
    checks++; if (rxr_valid !== 1'b0) $display("FAIL full_end_valid got %0b want 0", rxr_valid); else passes++;
    send_frame(4, 8'h11, 1'b0);
    checks++; if (ev_rx_done !== 1'b1) $display("FAIL short_ev got %0b want 1", ev_rx_done); else passes++;
    checks++; if (rx_len !== 16'd4) $display("FAIL short_len got %0d want 4", rx_len); else passes++;
    checks++; if (rx_drop_cnt !== 16'd3) $display("FAIL short_drop got %0d want 3", rx_drop_cnt); else passes++;
    pop_word(d, v);
    checks++; if (d !== 32'h1413_1211) $display("FAIL short_data got %h want 14131211", d); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_frame60();
    test_frame61();
    test_tuser_err();
    test_mac_enable();
    test_overflow();
    test_len_queue();
    test_fcs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
